// File: rtl/iserdes_strobe_deser_if.sv
// Serial-in / parallel-out bundle for the strobe-driven deserializer.
// The source side (serial driver) uses master; the deserializer uses slave.
interface iserdes_strobe_deser_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  D;
    logic                  IOCE;
    logic                  BITSLIP;
    logic [DATA_WIDTH-1:0] Q;
    logic                  VALID;
    logic                  TRAINED;
    logic [2:0]            SLIP;

    modport master (
        output D, IOCE, BITSLIP,
        input  Q, VALID, TRAINED, SLIP
    );

    modport slave (
        input  D, IOCE, BITSLIP,
        output Q, VALID, TRAINED, SLIP
    );
endinterface

// File: rtl/iserdes_strobe_deser.sv
// IOCLK-domain deserializer: shifts D every edge, captures a slip-aligned word on each
// IOCE strobe, steps the alignment on BITSLIP and tracks a training-pattern lock.
module iserdes_strobe_deser #(
    parameter int         DATA_WIDTH     = 4,
    parameter string      BITSLIP_ENABLE = "TRUE",
    parameter logic [7:0] TRAIN_PATTERN  = 8'hA5,
    parameter int         TRAIN_COUNT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    iserdes_strobe_deser_if.slave bus
);

    localparam int                    HIST_W     = 2 * DATA_WIDTH - 1;
    localparam bit                    SLIP_EN    = (BITSLIP_ENABLE == "TRUE");
    localparam logic [2:0]            SLIP_MAX   = 3'(DATA_WIDTH - 1);
    localparam logic [3:0]            TRAIN_MAX  = 4'(TRAIN_COUNT);
    localparam logic [DATA_WIDTH-1:0] TRAIN_WORD = TRAIN_PATTERN[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_width
            $error("iserdes_strobe_deser: DATA_WIDTH must be in 2..8");
        end
        if (TRAIN_COUNT < 1 || TRAIN_COUNT > 15) begin : g_bad_count
            $error("iserdes_strobe_deser: TRAIN_COUNT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } slip_state_t;

    logic [HIST_W-1:0]       hist;
    logic [2*DATA_WIDTH-1:0] nh;
    logic [2*DATA_WIDTH-1:0] nh_shifted;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [DATA_WIDTH-1:0]   q_reg;
    logic                    valid_reg;
    logic                    trained_reg;

    slip_state_t state, state_next;
    logic [2:0]  slip, slip_next;
    logic        slip_accept;

    logic [3:0]  cnt, cnt_next;
    logic        word_match;

    // The newest sample sits in bit 0; a larger slip looks further back in time.
    assign nh         = {hist, bus.D};
    assign nh_shifted = nh >> slip;
    assign load_word  = nh_shifted[DATA_WIDTH-1:0];
    assign word_match = (load_word == TRAIN_WORD);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // leaves it holding its previous value and a latch is never inferred.
    always_comb begin
        state_next  = state;
        slip_next   = slip;
        slip_accept = 1'b0;
        if (bus.IOCE) begin
            case (state)
                IDLE: begin
                    if (bus.BITSLIP && SLIP_EN) begin
                        slip_accept = 1'b1;
                        slip_next   = (slip == SLIP_MAX) ? 3'd0 : slip + 3'd1;
                        state_next  = LOCK1;
                    end
                end
                LOCK1:   state_next = LOCK2;
                LOCK2:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Match counter saturates at TRAIN_COUNT; an accepted slip always restarts it.
    always_comb begin
        cnt_next = cnt;
        if (bus.IOCE) begin
            if (slip_accept) begin
                cnt_next = 4'd0;
            end else if (word_match) begin
                cnt_next = (cnt == TRAIN_MAX) ? TRAIN_MAX : cnt + 4'd1;
            end else begin
                cnt_next = 4'd0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values and the order of statements inside the block does not matter.
    // NOTE: the history shift register is reset along with the rest, because the
    // first words after reset must see zeros in the bits not yet received.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist        <= '0;
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            trained_reg <= 1'b0;
            state       <= IDLE;
            slip        <= 3'd0;
            cnt         <= 4'd0;
        end else begin
            hist      <= nh[HIST_W-1:0];
            state     <= state_next;
            slip      <= slip_next;
            cnt       <= cnt_next;
            valid_reg <= bus.IOCE;
            if (bus.IOCE) begin
                q_reg       <= load_word;
                trained_reg <= (cnt_next == TRAIN_MAX);
            end
        end
    end

    assign bus.Q       = q_reg;
    assign bus.VALID   = valid_reg;
    assign bus.TRAINED = trained_reg;
    assign bus.SLIP    = slip;

endmodule
